// File: rtl/frame_ram_scanner_pkg.sv
// Shared definitions for the frame RAM scanner and its ILA/VIO glue:
// scan mode codes and the FSM state encoding.
package frame_ram_scanner_pkg;

  localparam logic [1:0] SCAN_SINGLE = 2'd0;
  localparam logic [1:0] SCAN_CONT   = 2'd1;
  localparam logic [1:0] SCAN_WINDOW = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_t;

  // The reserved mode code behaves as a single-frame scan.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == SCAN_CONT || m == SCAN_WINDOW) ? m : SCAN_SINGLE;
  endfunction

endpackage

// File: rtl/frame_ram_scanner_scan_valid_delay.sv
// Shift register that delays the {valid, last, addr} tag of each issued read so it
// lines up with the registered RAM data. Synchronous clear flushes every stage.
module scan_valid_delay #(
  parameter int LAT = 2,
  parameter int NB  = 12
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [NB-1:0] d,
  output logic [NB-1:0] q,
  output logic          q_next_valid
);

  logic [NB-1:0] stage [LAT];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[LAT-1];

  // Valid bit about to enter the output stage: the top uses it to capture RAM data.
  generate
    if (LAT == 1) begin : g_lat1
      assign q_next_valid = d[NB-1];
    end else begin : g_latn
      assign q_next_valid = stage[LAT-2][NB-1];
    end
  endgenerate

endmodule

// File: rtl/frame_ram_scanner.sv
// Frame RAM debug scanner: owns the RAM debug port, streams address-tagged samples
// (single / continuous / window scans) and latches per-frame threshold statistics.
module frame_ram_scanner
  import frame_ram_scanner_pkg::*;
#(
  parameter int COLS    = 24,
  parameter int ROWS    = 24,
  parameter int NB_DATA = 12,
  parameter int RD_LAT  = 2,
  parameter int NB_ADDR = $clog2(COLS*ROWS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [1:0]         i_mode,
  input  logic [NB_ADDR-1:0] i_win_start,
  input  logic [NB_ADDR-1:0] i_win_end,
  input  logic [NB_DATA-1:0] i_umbral,
  input  logic [NB_DATA-1:0] i_ram_data,
  output logic               o_ram_dbg,
  output logic [NB_ADDR-1:0] o_ram_addr,
  output logic [NB_DATA-1:0] o_data,
  output logic [NB_ADDR-1:0] o_data_addr,
  output logic               o_data_valid,
  output logic               o_frame_last,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [NB_ADDR:0]   o_cnt_above,
  output logic [NB_DATA-1:0] o_max
);

  localparam int unsigned        N_PIX     = COLS * ROWS;
  localparam logic [NB_ADDR:0]   N_W       = (NB_ADDR+1)'(N_PIX);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_PIX - 1);
  localparam int                 NB_LAT    = $clog2(RD_LAT + 1);

  scan_state_t        state, state_next;
  logic [1:0]         mode_q;
  logic [NB_ADDR-1:0] first_q, last_q, addr_q;
  logic [NB_DATA-1:0] umbral_q, acc_max;
  logic [NB_ADDR:0]   acc_cnt;
  logic [NB_LAT-1:0]  drain_cnt;
  logic               err_done_q;
  logic               start_req, start_win, win_ok, start_ok, start_bad;
  logic               abort_run, issue, clr, dly_next_valid;
  logic [NB_ADDR+1:0] dly_d, dly_q;

  assign start_win = (norm_mode(i_mode) == SCAN_WINDOW);
  assign win_ok    = !start_win ||
                     ((i_win_start <= i_win_end) && ({1'b0, i_win_end} < N_W));
  assign start_req = (state == ST_IDLE) && i_start && !i_abort;
  assign start_ok  = start_req && win_ok;
  assign start_bad = start_req && !win_ok;
  assign abort_run = i_abort && (state == ST_ARM || state == ST_SCAN || state == ST_DRAIN);
  assign clr       = rst || abort_run;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_ok) state_next = ST_ARM;
      ST_ARM:   state_next = i_abort ? ST_IDLE : ST_SCAN;
      ST_SCAN:  if (i_abort) state_next = ST_IDLE;
                else if (addr_q == last_q) state_next = ST_DRAIN;
      ST_DRAIN: if (i_abort) state_next = ST_IDLE;
                else if (drain_cnt == NB_LAT'(RD_LAT - 1)) state_next = ST_DONE;
      ST_DONE:  state_next = (mode_q == SCAN_CONT && !i_abort) ? ST_ARM : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (state != ST_IDLE);
    o_ram_dbg = (state != ST_IDLE);
    o_done    = (state == ST_DONE) || err_done_q;
    issue     = (state == ST_SCAN);
  end

  assign o_ram_addr = addr_q;

  // No backpressure: o_data_valid qualifies o_data/o_data_addr/o_frame_last for
  // exactly one cycle and the consumer must take every sample.
  assign dly_d = issue ? {1'b1, (addr_q == last_q), addr_q} : '0;

  scan_valid_delay #(.LAT(RD_LAT), .NB(NB_ADDR+2)) u_delay (
    .clk          (clk),
    .clr          (clr),
    .d            (dly_d),
    .q            (dly_q),
    .q_next_valid (dly_next_valid)
  );

  assign o_data_valid = dly_q[NB_ADDR+1];
  assign o_frame_last = dly_q[NB_ADDR];
  assign o_data_addr  = dly_q[NB_ADDR-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= SCAN_SINGLE;
      first_q     <= '0;
      last_q      <= '0;
      addr_q      <= '0;
      umbral_q    <= '0;
      acc_cnt     <= '0;
      acc_max     <= '0;
      drain_cnt   <= '0;
      err_done_q  <= 1'b0;
      o_err       <= 1'b0;
      o_cnt_above <= '0;
      o_max       <= '0;
      o_data      <= '0;
    end else begin
      err_done_q <= start_bad;
      if (start_bad)     o_err <= 1'b1;
      else if (start_ok) o_err <= 1'b0;

      if (start_ok) begin
        mode_q   <= norm_mode(i_mode);
        umbral_q <= i_umbral;
        first_q  <= start_win ? i_win_start : '0;
        last_q   <= start_win ? i_win_end   : LAST_ADDR;
        addr_q   <= start_win ? i_win_start : '0;
      end else if (state == ST_DONE && state_next == ST_ARM) begin
        addr_q <= first_q;
      end else if (issue && addr_q != last_q) begin
        addr_q <= addr_q + 1'b1;
      end

      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;

      if (state == ST_ARM) begin
        acc_cnt <= '0;
        acc_max <= '0;
      end else if (o_data_valid) begin
        if (o_data > umbral_q && acc_cnt < N_W) acc_cnt <= acc_cnt + 1'b1;
        if (o_data > acc_max) acc_max <= o_data;
      end

      if (state == ST_DONE) begin
        o_cnt_above <= acc_cnt;
        o_max       <= acc_max;
      end

      o_data <= (!abort_run && dly_next_valid) ? i_ram_data : '0;
    end
  end

endmodule

// File: tb/tb_frame_ram_scanner.sv
// Bench for frame_ram_scanner: RAM model returning data = address, a scoreboard queue of
// expected {last, addr} samples, a table of frame vectors and hand-written corner sequences.
module tb_frame_ram_scanner;
  import frame_ram_scanner_pkg::*;

  localparam int COLS    = 24;
  localparam int ROWS    = 24;
  localparam int NB_DATA = 12;
  localparam int RD_LAT  = 2;
  localparam int NB_ADDR = $clog2(COLS*ROWS);
  localparam int N_PIX   = COLS * ROWS;

  logic               clk;
  logic               rst;
  logic               start, abort;
  logic [1:0]         mode;
  logic [NB_ADDR-1:0] win_start, win_end;
  logic [NB_DATA-1:0] umbral, ram_data;
  logic               ram_dbg;
  logic [NB_ADDR-1:0] ram_addr, data_addr;
  logic [NB_DATA-1:0] data, max_val;
  logic               data_valid, frame_last, busy, done, err;
  logic [NB_ADDR:0]   cnt_above;

  frame_ram_scanner #(
    .COLS(COLS), .ROWS(ROWS), .NB_DATA(NB_DATA), .RD_LAT(RD_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_abort      (abort),
    .i_mode       (mode),
    .i_win_start  (win_start),
    .i_win_end    (win_end),
    .i_umbral     (umbral),
    .i_ram_data   (ram_data),
    .o_ram_dbg    (ram_dbg),
    .o_ram_addr   (ram_addr),
    .o_data       (data),
    .o_data_addr  (data_addr),
    .o_data_valid (data_valid),
    .o_frame_last (frame_last),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_cnt_above  (cnt_above),
    .o_max        (max_val)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // RAM model: RD_LAT-1 registers in front of the scanner's own output register
  generate
    if (RD_LAT == 1) begin : g_ram1
      assign ram_data = NB_DATA'(ram_addr);
    end else begin : g_ramn
      logic [NB_ADDR-1:0] pipe [RD_LAT-1];
      always @(posedge clk) begin
        pipe[0] <= ram_addr;
        for (int i = 1; i < RD_LAT-1; i++) pipe[i] <= pipe[i-1];
      end
      assign ram_data = NB_DATA'(pipe[RD_LAT-2]);
    end
  endgenerate

  // scoreboard
  logic [NB_ADDR:0] exp_q[$];
  int gap_q[$];
  int n_vec = 0;
  int n_err = 0;
  int last_cyc = -1;
  int prev_valid_cyc = -1;
  int done_cnt = 0;

  always @(negedge clk) begin
    logic [NB_ADDR:0]   e;
    logic [NB_DATA-1:0] exp_data;
    if (done) done_cnt++;
    if (data_valid) begin
      if (prev_valid_cyc >= 0 && cyc - prev_valid_cyc > 1) gap_q.push_back(cyc - prev_valid_cyc - 1);
      prev_valid_cyc = cyc;
      if (frame_last) last_cyc = cyc;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sample: unexpected valid addr=%0d data=%0d, required no valid", data_addr, data);
      end else begin
        e = exp_q.pop_front();
        exp_data = NB_DATA'(e[NB_ADDR-1:0]);
        if (data_addr !== e[NB_ADDR-1:0] || frame_last !== e[NB_ADDR] || data !== exp_data) begin
          n_err++;
          $display("FAIL sample: got addr=%0d last=%0b data=%0d, required addr=%0d last=%0b data=%0d",
                   data_addr, frame_last, data, e[NB_ADDR-1:0], e[NB_ADDR], exp_data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic push_frame(input int first, input int last);
    for (int a = first; a <= last; a++) exp_q.push_back({(a == last), NB_ADDR'(a)});
  endtask

  task automatic push_partial(input int first, input int upto);
    for (int a = first; a <= upto; a++) exp_q.push_back({1'b0, NB_ADDR'(a)});
  endtask

  task automatic drive_start(input logic [1:0] m, input int ws, input int we, input int umb);
    @(negedge clk);
    start     = 1'b1;
    mode      = m;
    win_start = NB_ADDR'(ws);
    win_end   = NB_ADDR'(we);
    umbral    = NB_DATA'(umb);
    @(negedge clk);
    start     = 1'b0;
    mode      = 2'($urandom_range(0, 3));
    win_start = NB_ADDR'($urandom_range(0, N_PIX-1));
    win_end   = NB_ADDR'($urandom_range(0, N_PIX-1));
    umbral    = NB_DATA'($urandom_range(0, 4095));
  endtask

  task automatic wait_done(input int budget, output int done_at);
    bit ok = 0;
    done_at = -1;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        ok = 1;
        done_at = cyc;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_addr(input int a, input int budget);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (busy && ram_addr == NB_ADDR'(a)) begin
        ok = 1;
        break;
      end
    end
    check("addr_reached", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [1:0] mode;
    int         ws;
    int         we;
    int         umb;
    bit         err;
    int         cnt;
    int         mx;
  } vec_t;

  vec_t vt[8];

  initial begin
    int done_at, base, first, last;
    bit is_win;

    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = SCAN_SINGLE;
    win_start = '0; win_end = '0; umbral = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_dbg", 32'(ram_dbg), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cnt", 32'(cnt_above), 0);
    check("rst_max", 32'(max_val), 0);
    rst = 1'b0;

    vt[0] = '{SCAN_SINGLE, 0,   0,   100, 1'b0, 475, 575};
    vt[1] = '{SCAN_WINDOW, 10,  19,  100, 1'b0, 0,   19};
    vt[2] = '{SCAN_WINDOW, 20,  5,   0,   1'b1, 0,   19};
    vt[3] = '{SCAN_WINDOW, 0,   576, 0,   1'b1, 0,   19};
    vt[4] = '{SCAN_WINDOW, 570, 575, 572, 1'b0, 3,   575};
    vt[5] = '{2'd3,        0,   0,   574, 1'b0, 1,   575};
    vt[6] = '{SCAN_WINDOW, 0,   0,   0,   1'b0, 0,   0};
    vt[7] = '{SCAN_WINDOW, 575, 575, 574, 1'b0, 1,   575};

    for (int v = 0; v < 8; v++) begin
      is_win = (vt[v].mode == SCAN_WINDOW);
      first  = is_win ? vt[v].ws : 0;
      last   = is_win ? vt[v].we : N_PIX - 1;
      if (!vt[v].err) push_frame(first, last);
      drive_start(vt[v].mode, vt[v].ws, vt[v].we, vt[v].umb);
      if (!vt[v].err) begin
        check("arm_busy", 32'(busy), 1);
        check("arm_dbg", 32'(ram_dbg), 1);
        check("arm_addr", 32'(ram_addr), 32'(first));
      end
      wait_done(N_PIX + 50, done_at);
      check("err_flag", 32'(err), 32'(vt[v].err));
      check("busy_at_done", 32'(busy), 32'(!vt[v].err));
      if (!vt[v].err) check("done_after_last", 32'(done_at), 32'(last_cyc + 1));
      @(negedge clk);
      check("done_pulse", 32'(done), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_dbg", 32'(ram_dbg), 0);
      check("cnt_above", 32'(cnt_above), 32'(vt[v].cnt));
      check("max", 32'(max_val), 32'(vt[v].mx));
      check("queue_empty", 32'(exp_q.size()), 0);
    end

    // start pulses during SCAN are ignored
    push_frame(0, N_PIX - 1);
    drive_start(SCAN_SINGLE, 0, 0, 100);
    wait_addr(50, N_PIX);
    start = 1'b1; mode = SCAN_WINDOW; win_start = 3; win_end = 4; umbral = 0;
    @(negedge clk);
    start = 1'b0;
    wait_done(N_PIX + 50, done_at);
    @(negedge clk);
    check("midstart_cnt", 32'(cnt_above), 475);
    check("midstart_max", 32'(max_val), 575);
    check("midstart_queue", 32'(exp_q.size()), 0);

    // continuous: three full frames, abort at address 300 of the fourth
    prev_valid_cyc = -1;
    gap_q.delete();
    for (int f = 0; f < 3; f++) push_frame(0, N_PIX - 1);
    push_partial(0, 300 - RD_LAT);
    base = done_cnt;
    drive_start(SCAN_CONT, 0, 0, 100);
    for (int k = 0; k < 4 * N_PIX && done_cnt < base + 3; k++) @(negedge clk);
    check("cont_three_done", 32'(done_cnt - base), 3);
    wait_addr(300, N_PIX);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_dbg", 32'(ram_dbg), 0);
    check("abort_valid", 32'(data_valid), 0);
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - base), 3);
    check("abort_queue", 32'(exp_q.size()), 0);
    check("cont_gaps", 32'(gap_q.size()), 3);
    while (gap_q.size() > 0) check("cont_gap_len", 32'(gap_q.pop_front()), 32'(RD_LAT + 2));
    check("abort_cnt", 32'(cnt_above), 475);
    check("abort_max", 32'(max_val), 575);

    // reset mid-scan clears everything, then a full frame completes
    push_partial(0, 100 - RD_LAT);
    drive_start(SCAN_SINGLE, 0, 0, 100);
    wait_addr(100, N_PIX);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_dbg", 32'(ram_dbg), 0);
    check("rst_mid_addr", 32'(ram_addr), 0);
    check("rst_mid_valid", 32'(data_valid), 0);
    check("rst_mid_data", 32'(data), 0);
    check("rst_mid_daddr", 32'(data_addr), 0);
    check("rst_mid_last", 32'(frame_last), 0);
    check("rst_mid_cnt", 32'(cnt_above), 0);
    check("rst_mid_max", 32'(max_val), 0);
    check("rst_mid_done", 32'(done), 0);
    rst = 1'b0;
    check("rst_mid_queue", 32'(exp_q.size()), 0);
    push_frame(0, N_PIX - 1);
    drive_start(SCAN_SINGLE, 0, 0, 100);
    wait_done(N_PIX + 50, done_at);
    @(negedge clk);
    check("post_rst_cnt", 32'(cnt_above), 475);
    check("post_rst_max", 32'(max_val), 575);
    check("post_rst_queue", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
